// File: rtl/mdu_ctrl_pkg.sv
// ============================================================================
// Module : mdu_ctrl_pkg
// Brief  : Shared MDU operation codes and controller state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mdu_ctrl_pkg;

  localparam logic [2:0] MDOP_MULT  = 3'd0;
  localparam logic [2:0] MDOP_MULTU = 3'd1;
  localparam logic [2:0] MDOP_DIV   = 3'd2;
  localparam logic [2:0] MDOP_DIVU  = 3'd3;
  localparam logic [2:0] MDOP_MTHI  = 3'd4;
  localparam logic [2:0] MDOP_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
           (op == MDOP_DIV)  || (op == MDOP_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MDOP_DIV) || (op == MDOP_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// ============================================================================
// Module : mdu_arith
// Brief  : Combinational multiply/divide datapath producing HI/LO results.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div0
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] b_safe;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // A zero divisor is replaced by 1 so the dividers never see it; the result is discarded anyway.
  assign div0   = is_div(op) && (b == 32'd0);
  assign b_safe = (b == 32'd0) ? 32'd1 : b;

  // Signed divide on magnitudes: 0x80000000 / -1 naturally yields 0x80000000 rem 0.
  assign sign_a = a[31];
  assign sign_b = b_safe[31];
  assign a_mag  = sign_a ? (~a + 32'd1) : a;
  assign b_mag  = sign_b ? (~b_safe + 32'd1) : b_safe;
  assign q_mag  = a_mag / b_mag;
  assign r_mag  = a_mag % b_mag;
  assign q_s    = (sign_a ^ sign_b) ? (~q_mag + 32'd1) : q_mag;
  assign r_s    = sign_a ? (~r_mag + 32'd1) : r_mag;

  assign q_u    = a / b_safe;
  assign r_u    = a % b_safe;

  always_comb begin
    hi_res = 32'd0;
    lo_res = 32'd0;
    case (op)
      MDOP_MULT:  {hi_res, lo_res} = prod_s;
      MDOP_MULTU: {hi_res, lo_res} = prod_u;
      MDOP_DIV: begin
        hi_res = r_s;
        lo_res = q_s;
      end
      MDOP_DIVU: begin
        hi_res = r_u;
        lo_res = q_u;
      end
      default: begin
        hi_res = 32'd0;
        lo_res = 32'd0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
// Module : mdu_ctrl
// Brief  : E-stage MDU controller: fixed-latency busy tracking and HI/LO ownership.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic        HLWE,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             busy_q,  busy_d;
  logic [31:0]      hi_q,    hi_d;
  logic [31:0]      lo_q,    lo_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic             div0_q,  div0_d;

  logic [31:0]      arith_hi;
  logic [31:0]      arith_lo;
  logic             arith_div0;
  logic             start_ok;
  logic             hlwe_ok;

  mdu_arith u_arith (
    .op     (MDOp),
    .a      (A),
    .b      (B),
    .hi_res (arith_hi),
    .lo_res (arith_lo),
    .div0   (arith_div0)
  );

  assign start_ok = Start && !Req && is_muldiv(MDOp);
  assign hlwe_ok  = HLWE && !Req && ((MDOp == MDOP_MTHI) || (MDOp == MDOP_MTLO));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    div0_d   = div0_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d  = ST_RUN;
          busy_d   = 1'b1;
          cnt_d    = is_div(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          res_hi_d = arith_hi;
          res_lo_d = arith_lo;
          div0_d   = arith_div0;
        end else if (hlwe_ok) begin
          if (MDOp == MDOP_MTHI) hi_d = A;
          else                   lo_d = A;
        end
      end
      ST_RUN: begin
        // Start/HLWE are ignored here; Req no longer matters once the op is accepted.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          if (!div0_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      div0_q   <= div0_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

`default_nettype wire
